// File: rtl/bus_pkg.sv
// Shared encodings for the 16-bit register bus sequencer.
// Op codes, FSM states and default bus width.
package bus_pkg;

    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        OP_MOV = 2'b00,
        OP_LDI = 2'b01,
        OP_RD  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DRV  = 2'b01,
        ST_WRT  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot decoder with enable.
// Out-of-range indices decode to all zeros.
module onehot_dec #(
    parameter int NREG = 8,
    parameter int IW   = $clog2(NREG)
) (
    input  logic            i_en,
    input  logic [IW-1:0]   i_idx,
    output logic [NREG-1:0] o_oh
);

    always_comb begin
        o_oh = '0;
        for (int i = 0; i < NREG; i++) begin
            o_oh[i] = i_en && (i_idx == IW'(i));
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register bus sequencer: MOV, LDI and RD commands issued as
// registered one-hot load-to-bus / write strobes over DRV, WRT, DONE.
module bus_xfer_ctrl
    import bus_pkg::*;
#(
    parameter  int NREG = 8,
    parameter  int DW   = DW_DEF,
    localparam int IW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [IW-1:0]   src,
    input  logic [IW-1:0]   dst,
    input  logic [DW-1:0]   imm,
    input  logic [DW-1:0]   bus_in,
    output logic [DW-1:0]   bus_out,
    output logic            bus_oe,
    output logic [NREG-1:0] ldbus,
    output logic [NREG-1:0] wr,
    output logic [DW-1:0]   data_out,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [IW:0] NREG_W = (IW+1)'(NREG);

    state_e          r_state;
    state_e          w_nstate;
    op_e             r_op;
    op_e             w_op;
    logic [IW-1:0]   r_src;
    logic [IW-1:0]   r_dst;
    logic [IW-1:0]   w_src;
    logic [IW-1:0]   w_dst;
    logic [DW-1:0]   r_imm;
    logic [DW-1:0]   r_data;
    logic [NREG-1:0] r_ldbus;
    logic [NREG-1:0] r_wr;
    logic [NREG-1:0] w_ldbus;
    logic [NREG-1:0] w_wr;
    logic            r_oe;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            w_idle;
    logic            w_src_ok;
    logic            w_dst_ok;
    logic            w_valid;
    logic            w_accept;
    logic            w_rej;
    logic            w_drive;
    logic            w_ld_en;
    logic            w_wr_en;

    // DONE counts as idle so a new command can start as DONE closes.
    assign w_idle   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_src_ok = {1'b0, src} < NREG_W;
    assign w_dst_ok = {1'b0, dst} < NREG_W;

    always_comb begin
        w_valid = 1'b0;
        unique case (op_e'(op))
            OP_MOV:  w_valid = w_src_ok && w_dst_ok;
            OP_LDI:  w_valid = w_dst_ok;
            OP_RD:   w_valid = w_src_ok;
            default: w_valid = 1'b0;
        endcase
    end

    assign w_accept = w_idle && start && w_valid;
    assign w_rej    = w_idle && start && !w_valid;

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: w_nstate = w_accept ? ST_DRV : ST_IDLE;
            ST_DRV:           w_nstate = ST_WRT;
            ST_WRT:           w_nstate = ST_DONE;
            default:          w_nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    // Strobes are decoded from the next state so they leave a register.
    assign w_op    = w_accept ? op_e'(op) : r_op;
    assign w_src   = w_accept ? src : r_src;
    assign w_dst   = w_accept ? dst : r_dst;
    assign w_drive = (w_nstate == ST_DRV) || (w_nstate == ST_WRT);
    assign w_ld_en = w_drive && (w_op != OP_LDI);
    assign w_wr_en = (w_nstate == ST_WRT) && (w_op != OP_RD);

    onehot_dec #(
        .NREG (NREG),
        .IW   (IW)
    ) u_ld_dec (
        .i_en  (w_ld_en),
        .i_idx (w_src),
        .o_oh  (w_ldbus)
    );

    onehot_dec #(
        .NREG (NREG),
        .IW   (IW)
    ) u_wr_dec (
        .i_en  (w_wr_en),
        .i_idx (w_dst),
        .o_oh  (w_wr)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            r_op    <= OP_MOV;
            r_src   <= '0;
            r_dst   <= '0;
            r_imm   <= '0;
            r_ldbus <= '0;
            r_wr    <= '0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= op_e'(op);
                r_src <= src;
                r_dst <= dst;
                r_imm <= imm;
            end
            r_ldbus <= w_ldbus;
            r_wr    <= w_wr;
            r_oe    <= w_drive && (w_op == OP_LDI);
            r_busy  <= w_drive;
            r_done  <= (w_nstate == ST_DONE);
            r_err   <= w_rej;
            if ((r_state == ST_WRT) && (r_op == OP_RD)) begin
                r_data <= bus_in;
            end
        end
    end

    assign bus_out  = r_oe ? r_imm : {DW{1'bz}};
    assign bus_oe   = r_oe;
    assign ldbus    = r_ldbus;
    assign wr       = r_wr;
    assign data_out = r_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: command table plus hand sequences, with a
// small register bank model resolving the bus around the DUT.
module tb_bus_xfer_ctrl;
    import bus_pkg::*;

    localparam int NREG = 8;
    localparam int DW   = 16;
    localparam int IW   = 3;

    logic            clk = 1'b0;
    logic            RST = 1'b1;
    logic            start;
    logic [1:0]      op;
    logic [IW-1:0]   src;
    logic [IW-1:0]   dst;
    logic [DW-1:0]   imm;
    logic [DW-1:0]   bus_in;
    wire  [DW-1:0]   bus_out;
    logic            bus_oe;
    logic [NREG-1:0] ldbus;
    logic [NREG-1:0] wr;
    logic [DW-1:0]   data_out;
    logic            busy;
    logic            done;
    logic            err;

    logic            start6;
    logic [1:0]      op6;
    logic [2:0]      src6;
    logic [2:0]      dst6;
    logic [DW-1:0]   imm6;
    logic [DW-1:0]   bus_in6;
    wire  [DW-1:0]   bus_out6;
    logic            bus_oe6;
    logic [5:0]      ldbus6;
    logic [5:0]      wr6;
    logic [DW-1:0]   data_out6;
    logic            busy6;
    logic            done6;
    logic            err6;

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.NREG(NREG), .DW(DW)) u_dut (
        .clk(clk), .RST(RST), .start(start), .op(op),
        .src(src), .dst(dst), .imm(imm), .bus_in(bus_in),
        .bus_out(bus_out), .bus_oe(bus_oe), .ldbus(ldbus),
        .wr(wr), .data_out(data_out), .busy(busy),
        .done(done), .err(err)
    );

    bus_xfer_ctrl #(.NREG(6), .DW(DW)) u_dut6 (
        .clk(clk), .RST(RST), .start(start6), .op(op6),
        .src(src6), .dst(dst6), .imm(imm6), .bus_in(bus_in6),
        .bus_out(bus_out6), .bus_oe(bus_oe6), .ldbus(ldbus6),
        .wr(wr6), .data_out(data_out6), .busy(busy6),
        .done(done6), .err(err6)
    );

    // Register bank model (no reset; contents set through LDI).
    logic [DW-1:0] regs [NREG];

    always_comb begin
        bus_in = '0;
        if (bus_oe) begin
            bus_in = bus_out;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (ldbus[i]) bus_in = bus_in | regs[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++)
            if (wr[i]) regs[i] <= bus_in;
    end

    int cyc = 0;
    int done_cnt = 0;
    int last_done = 0;
    int prev_done = 0;
    int inv_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt  = done_cnt + 1;
            prev_done = last_done;
            last_done = cyc;
        end
        if (!RST && (($countones(ldbus) > 1) || ($countones(wr) > 1)
                     || ((|ldbus) && bus_oe)))
            inv_bad = inv_bad + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  src;
        logic [2:0]  dst;
        logic [15:0] imm;
        logic        e_err;
        logic [7:0]  e_ld;
        logic        e_oe;
        logic [7:0]  e_wr;
        int          kind;   // 0 none, 1 register e_reg, 2 data_out
        int          e_reg;
        logic [15:0] e_val;
    } vec_t;

    vec_t vt [9];

    task automatic run_vec(input int k);
        vec_t v;
        v = vt[k];
        @(negedge clk);
        start = 1'b1; op = v.op; src = v.src; dst = v.dst; imm = v.imm;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d c1 err", k), err, v.e_err);
        chk($sformatf("v%0d c1 busy", k), busy, !v.e_err);
        chk($sformatf("v%0d c1 ldbus", k), ldbus, v.e_ld);
        chk($sformatf("v%0d c1 oe", k), bus_oe, v.e_oe);
        chk($sformatf("v%0d c1 wr", k), wr, 8'h00);
        @(negedge clk);
        chk($sformatf("v%0d c2 err", k), err, 1'b0);
        chk($sformatf("v%0d c2 ldbus", k), ldbus, v.e_ld);
        chk($sformatf("v%0d c2 oe", k), bus_oe, v.e_oe);
        chk($sformatf("v%0d c2 wr", k), wr, v.e_wr);
        if (v.e_oe) chk($sformatf("v%0d c2 bus", k), bus_in, v.imm);
        @(negedge clk);
        chk($sformatf("v%0d c3 done", k), done, !v.e_err);
        chk($sformatf("v%0d c3 busy", k), busy, 1'b0);
        chk($sformatf("v%0d c3 strobes", k), {ldbus, wr, bus_oe}, 17'h0);
        if (v.kind == 1)
            chk($sformatf("v%0d reg", k), regs[v.e_reg], v.e_val);
        if (v.kind == 2)
            chk($sformatf("v%0d data", k), data_out, v.e_val);
        @(negedge clk);
    endtask

    int base;

    initial begin
        start = 0; op = 0; src = 0; dst = 0; imm = 0;
        start6 = 0; op6 = 0; src6 = 0; dst6 = 0; imm6 = 0; bus_in6 = 0;

        vt[0] = '{2'b01, 3'd0, 3'd2, 16'hA5A5, 1'b0, 8'h00, 1'b1, 8'h04, 1, 2, 16'hA5A5};
        vt[1] = '{2'b00, 3'd2, 3'd5, 16'h0000, 1'b0, 8'h04, 1'b0, 8'h20, 1, 5, 16'hA5A5};
        vt[2] = '{2'b10, 3'd2, 3'd0, 16'h0000, 1'b0, 8'h04, 1'b0, 8'h00, 2, 0, 16'hA5A5};
        vt[3] = '{2'b01, 3'd0, 3'd7, 16'h1234, 1'b0, 8'h00, 1'b1, 8'h80, 1, 7, 16'h1234};
        vt[4] = '{2'b01, 3'd0, 3'd0, 16'hBEEF, 1'b0, 8'h00, 1'b1, 8'h01, 1, 0, 16'hBEEF};
        vt[5] = '{2'b10, 3'd0, 3'd6, 16'h0000, 1'b0, 8'h01, 1'b0, 8'h00, 2, 0, 16'hBEEF};
        vt[6] = '{2'b00, 3'd7, 3'd7, 16'h0000, 1'b0, 8'h80, 1'b0, 8'h80, 1, 7, 16'h1234};
        vt[7] = '{2'b11, 3'd1, 3'd2, 16'h0000, 1'b1, 8'h00, 1'b0, 8'h00, 0, 0, 16'h0000};
        vt[8] = '{2'b01, 3'd0, 3'd3, 16'h3333, 1'b0, 8'h00, 1'b1, 8'h08, 1, 3, 16'h3333};

        repeat (3) @(negedge clk);
        chk("rst ldbus", ldbus, 8'h00);
        chk("rst wr", wr, 8'h00);
        chk("rst oe/busy/done/err", {bus_oe, busy, done, err}, 4'h0);
        chk("rst data_out", data_out, 16'h0000);
        RST = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 9; k++) run_vec(k);

        // rejected command, valid start in the err cycle
        @(negedge clk);
        start = 1; op = 2'b11;
        @(negedge clk);
        chk("rej err", err, 1'b1);
        chk("rej busy", busy, 1'b0);
        op = 2'b01; dst = 3'd6; imm = 16'h0606;
        @(negedge clk);
        start = 0;
        chk("rej next busy", busy, 1'b1);
        chk("rej next err", err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rej next done", done, 1'b1);
        chk("rej next reg6", regs[6], 16'h0606);

        // start held through DRV/WRT is ignored
        @(negedge clk);
        base = done_cnt;
        start = 1; op = 2'b01; dst = 3'd1; imm = 16'h0101;
        @(negedge clk);
        dst = 3'd2; imm = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        chk("busy start done count", done_cnt - base, 1);
        chk("busy start reg2", regs[2], 16'hA5A5);
        chk("busy start reg1", regs[1], 16'h0101);

        // reset during DRV of MOV R0->R3
        base = done_cnt;
        @(negedge clk);
        start = 1; op = 2'b00; src = 3'd0; dst = 3'd3;
        @(negedge clk);
        start = 0;
        chk("rstdrv busy", busy, 1'b1);
        RST = 1;
        @(negedge clk);
        RST = 0;
        chk("rstdrv outs", {ldbus, wr, bus_oe, busy, done, err}, 20'h0);
        chk("rstdrv data", data_out, 16'h0000);
        repeat (4) @(negedge clk);
        chk("rstdrv no done", done_cnt - base, 0);
        chk("rstdrv reg3", regs[3], 16'h3333);

        // back-to-back LDI R1 then MOV R1->R4
        @(negedge clk);
        start = 1; op = 2'b01; dst = 3'd1; imm = 16'h0001;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        @(negedge clk);
        start = 1; op = 2'b00; src = 3'd1; dst = 3'd4;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        chk("b2b done spacing", last_done - prev_done, 3);
        chk("b2b reg4", regs[4], 16'h0001);

        // NREG=6 instance: out-of-range indices rejected
        @(negedge clk);
        start6 = 1; op6 = 2'b00; src6 = 3'd1; dst6 = 3'd7;
        @(negedge clk);
        chk("n6 mov err", err6, 1'b1);
        chk("n6 mov busy", busy6, 1'b0);
        op6 = 2'b10; src6 = 3'd6;
        @(negedge clk);
        chk("n6 rd err", err6, 1'b1);
        chk("n6 rd ldbus", ldbus6, 6'h00);
        op6 = 2'b01; dst6 = 3'd5; imm6 = 16'h5555;
        @(negedge clk);
        start6 = 0;
        chk("n6 ldi err", err6, 1'b0);
        chk("n6 ldi busy", busy6, 1'b1);
        @(negedge clk);
        chk("n6 ldi wr", wr6, 6'b100000);
        @(negedge clk);
        chk("n6 ldi done", done6, 1'b1);

        chk("strobe invariants", inv_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

Upstream sequencer for the shared 16-bit register bus. Accepts one transfer command at a time and issues the one-hot per-register load-to-bus and write strobes needed to complete it:
- register-to-register move,
- immediate load,
- register read-back to the controller.

It sits between the core's control unit and the bank of bus registers. It is the only agent allowed to drive register strobes and the immediate onto the bus.

## Interface
Parameters:
- NREG, 8, number of bus registers controlled (2..16)
- DW, 16, bus width
- IW, derived localparam = $clog2(NREG), register index width

Ports:
- clk  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-high
- start  in  1  command valid; sampled only when busy=0
- op  in  2  00=MOV, 01=LDI, 10=RD, 11=reserved
- src  in  IW  source register index (MOV, RD)
- dst  in  IW  destination register index (MOV, LDI)
- imm  in  DW  immediate value (LDI)
- bus_in  in  DW  resolved bus value
- bus_out  out  DW  controller bus drive; 'z when bus_oe=0
- bus_oe  out  1  controller drives bus
- ldbus  out  NREG  one-hot load-to-bus strobes
- wr  out  NREG  one-hot write strobes
- data_out  out  DW  last value captured by RD
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle rejection pulse

## Operation
- FSM states: IDLE, DRV, WRT, DONE.
- IDLE with start=1 and a valid command: latch op/src/dst/imm, go to DRV, busy=1.
- Invalid command: op=11, or any index used by the op that is ≥NREG.
  - err=1 on the next cycle.
  - Stay in IDLE; no strobes, no done.
- DRV, a one-cycle bus settle:
  - MOV/RD: ldbus[src]=1.
  - LDI: bus_oe=1, bus_out=imm.
  - Go to WRT.
- WRT:
  - Same drive as DRV.
  - MOV/LDI: additionally wr[dst]=1. The destination captures at the closing edge.
  - RD: data_out<=bus_in at the closing edge; no wr.
  - Go to DONE.
- DONE: all strobes and bus_oe low, done=1, busy=0 → IDLE.
- MOV with src==dst is legal and performs the transfer unchanged.
- start while busy=1 is ignored, not queued.
- At most one bit of ldbus and one bit of wr is high in any cycle. ldbus and bus_oe are never high together.
- All outputs come from registers (no combinational path from inputs to strobes).

## Timing
- Reset state: IDLE. ldbus=0, wr=0, bus_oe=0, bus_out='z, busy=0, done=0, err=0, data_out=0.
- Latency: start sampled at edge N; DRV in cycle N+1, WRT in N+2, done=1 in N+3.
- The next start is accepted at the edge ending the DONE cycle. Throughput is one command per 3 cycles.
- err is asserted in cycle N+1 for a rejected command. A new start is accepted in that same cycle.
- RST mid-operation: the next edge returns to IDLE with reset outputs, and no done is issued.
  - If RST is sampled in DRV, the destination is never written.
  - If RST is sampled in WRT, the destination's own RST (a shared signal, with priority) clears it.
- A RD with RST in WRT leaves data_out=0.

## Structure
- Shared package bus_pkg holds:
  - op encodings (OP_MOV, OP_LDI, OP_RD, OP_RSV),
  - the FSM state enum,
  - default DW=16.
- Sub-module onehot_dec (IW→NREG one-hot with enable) is instantiated twice, for ldbus and wr.
- The tri-state on bus_out is driven in this block from bus_oe, matching the register bank's 'z convention.

## Test plan
- MOV src=2, dst=5 with R2=16'hA5A5: ldbus[2] high for 2 cycles, wr[5] high in the second, done at N+3, R5=16'hA5A5, R2 unchanged.
- LDI dst=7, imm=16'h1234: bus_oe high 2 cycles with bus=16'h1234, wr[7] high only in WRT, R7=16'h1234 after done.
- RD src=0 with R0=16'hBEEF: data_out=16'hBEEF at done, no wr bit ever high.
- op=11, or NREG=6 with src=6: err pulse at N+1, no strobes, busy stays 0, and a valid start in that cycle completes normally.
- start re-asserted during DRV/WRT: ignored, only one done. RST in DRV of MOV to R3 gives R3 unchanged, all outputs at reset values next cycle, no done.
- Back-to-back LDI R1=16'h0001 then MOV R1→R4: R4=16'h0001, with the two done pulses 3 cycles apart.
